ahb_si_resp_mux: RTL and testbench

- Parametrised AHB slave-to-master response multiplexer for the generated interconnect.
- Captures the one-hot slave select during the address phase and holds it through the data phase. The held select routes the selected slave's HRDATA/HRESP/HREADYOUT back to the master.
- Contains an internal default slave: transfers that decode to no slave, or to more than one slave, get the AHB two-cycle ERROR response.
- One instance per master port, sitting between the decoder and the master.

---
 rtl/ahb_si_resp_mux_pkg.sv | 36 +++
 rtl/ahb_default_slave.sv | 87 ++++++++
 rtl/ahb_si_resp_mux.sv | 102 ++++++++++
 tb/tb_ahb_si_resp_mux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_si_resp_mux_pkg.sv
// Shared types and helpers for the AHB slave-to-master response multiplexer.
//   htrans_t      : AHB HTRANS encoding
//   HrespOkay/Err : HRESP encoding
//   dslv_state_t  : default-slave FSM states
//   is_onehot()   : 1 iff exactly one bit of the (zero-extended) select is set
package ahb_si_resp_mux_pkg;

    // Widest select supported by is_onehot(); narrower selects are zero-extended.
    localparam int unsigned MaxChannels = 16;

    typedef enum logic [1:0] {
        HtransIdle   = 2'd0,
        HtransBusy   = 2'd1,
        HtransNonseq = 2'd2,
        HtransSeq    = 2'd3
    } htrans_t;

    localparam logic HrespOkay  = 1'b0;
    localparam logic HrespError = 1'b1;

    typedef enum logic [1:0] {
        DsIdle = 2'd0,
        DsErr1 = 2'd1,
        DsErr2 = 2'd2
    } dslv_state_t;

    function automatic logic is_onehot(input logic [MaxChannels-1:0] vec);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < int'(MaxChannels); i++) begin
            ones = ones + 32'(vec[i]);
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Internal AHB default slave: produces the two-cycle ERROR response for
// transfers that decode to no slave (or to several), and counts them.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   arm           : address phase holds an erroring NONSEQ/SEQ transfer
//   hready        : bus HREADY; the arm is only taken on a completing cycle
//   ds_hready     : default-slave HREADYOUT (low in ERR1)
//   ds_hresp      : default-slave HRESP (ERROR in ERR1 and ERR2)
//   ds_active     : default slave owns the current data phase
//   err_cnt       : saturating count of ERROR responses started
module ahb_default_slave
    import ahb_si_resp_mux_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 arm,
    input  logic                 hready,
    output logic                 ds_hready,
    output logic                 ds_hresp,
    output logic                 ds_active,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    dslv_state_t state_q, state_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic capture;

    assign capture = arm & hready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DsIdle:  if (capture) state_d = DsErr1;
            DsErr1:  state_d = DsErr2;
            // A new erroring transfer captured on the completing ERR2 edge
            // restarts the response without passing through IDLE.
            DsErr2:  state_d = capture ? DsErr1 : DsIdle;
            default: state_d = DsIdle;
        endcase
    end

    // ERR1 is only ever entered from IDLE or ERR2, so entry == state_d is ERR1.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == DsErr1) && !(&cnt_q)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= DsIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ds_hready = 1'b1;
        ds_hresp  = HrespOkay;
        ds_active = 1'b0;
        unique case (state_q)
            DsErr1: begin
                ds_hready = 1'b0;
                ds_hresp  = HrespError;
                ds_active = 1'b1;
            end
            DsErr2: begin
                ds_hready = 1'b1;
                ds_hresp  = HrespError;
                ds_active = 1'b1;
            end
            default: begin
                ds_hready = 1'b1;
                ds_hresp  = HrespOkay;
                ds_active = 1'b0;
            end
        endcase
    end

    assign err_cnt = cnt_q;

endmodule

// File: rtl/ahb_si_resp_mux.sv
// AHB slave-to-master response multiplexer, one per master port.
// Registers the one-hot slave select at the end of each address phase and
// uses it to route the selected slave's HRDATA/HRESP/HREADYOUT back during
// the data phase. Non-one-hot selects fall to an internal default slave.
// Ports:
//   HCLK, HRESETn           : clock, asynchronous active-low reset
//   sel, htrans             : address-phase select (decoder) and HTRANS (master)
//   hrdata_in, hresp_in,
//   hreadyout_in            : per-slave data-phase responses
//   hrdata, hresp, hready   : muxed response to the master (hready also to slaves)
//   dsel                    : registered data-phase select
//   dec_err_cnt             : saturating count of default-slave ERROR transfers
module ahb_si_resp_mux
    import ahb_si_resp_mux_pkg::*;
#(
    parameter int unsigned CHANNEL_NUM = 3,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                                HCLK,
    input  logic                                HRESETn,
    input  logic [CHANNEL_NUM-1:0]              sel,
    input  logic [1:0]                          htrans,
    input  logic [CHANNEL_NUM-1:0][DATA_W-1:0]  hrdata_in,
    input  logic [CHANNEL_NUM-1:0]              hresp_in,
    input  logic [CHANNEL_NUM-1:0]              hreadyout_in,
    output logic [DATA_W-1:0]                   hrdata,
    output logic                                hresp,
    output logic                                hready,
    output logic [CHANNEL_NUM-1:0]              dsel,
    output logic [ERR_CNT_W-1:0]                dec_err_cnt
);

    logic [CHANNEL_NUM-1:0] dsel_q, dsel_d;
    htrans_t                htrans_e;
    logic                   sel_onehot;
    logic                   xfer_req;
    logic                   arm;
    logic                   ds_hready;
    logic                   ds_hresp;
    logic                   ds_active;

    assign htrans_e   = htrans_t'(htrans);
    assign sel_onehot = is_onehot(MaxChannels'(sel));
    assign xfer_req   = (htrans_e == HtransNonseq) || (htrans_e == HtransSeq);

    // IDLE/BUSY to an unmapped address is a zero-wait OKAY, so only real
    // transfers arm the default slave.
    assign arm = hready & ~sel_onehot & xfer_req;

    // Capture only on completing cycles; a stalled data phase keeps its slave.
    always_comb begin
        dsel_d = dsel_q;
        if (hready) begin
            dsel_d = sel_onehot ? sel : '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_q <= '0;
        end else begin
            dsel_q <= dsel_d;
        end
    end

    ahb_default_slave #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .arm       (arm),
        .hready    (hready),
        .ds_hready (ds_hready),
        .ds_hresp  (ds_hresp),
        .ds_active (ds_active),
        .err_cnt   (dec_err_cnt)
    );

    // The default slave and a real slave never own the same data phase:
    // the default slave is only armed when dsel is captured as zero.
    always_comb begin
        hrdata = '0;
        hresp  = HrespOkay;
        hready = 1'b1;
        if (ds_active) begin
            hready = ds_hready;
            hresp  = ds_hresp;
        end else begin
            for (int k = 0; k < int'(CHANNEL_NUM); k++) begin
                if (dsel_q[k]) begin
                    hrdata = hrdata_in[k];
                    hresp  = hresp_in[k];
                    hready = hreadyout_in[k];
                end
            end
        end
    end

    assign dsel = dsel_q;

endmodule

// File: tb/tb_ahb_si_resp_mux.sv
module tb_ahb_si_resp_mux;

    logic                  HCLK;
    logic                  HRESETn;
    logic [2:0]            sel;
    logic [1:0]            htrans;
    logic [2:0][31:0]      hrdata_in;
    logic [2:0]            hresp_in;
    logic [2:0]            hreadyout_in;

    logic [31:0]           hrdata;
    logic                  hresp;
    logic                  hready;
    logic [2:0]            dsel;
    logic [7:0]            dec_err_cnt;

    // Second instance with a 2-bit counter to exercise saturation.
    logic [31:0]           hrdata2;
    logic                  hresp2;
    logic                  hready2;
    logic [2:0]            dsel2;
    logic [1:0]            dec_err_cnt2;

    ahb_si_resp_mux #(
        .CHANNEL_NUM (3),
        .DATA_W      (32),
        .ERR_CNT_W   (8)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .sel          (sel),
        .htrans       (htrans),
        .hrdata_in    (hrdata_in),
        .hresp_in     (hresp_in),
        .hreadyout_in (hreadyout_in),
        .hrdata       (hrdata),
        .hresp        (hresp),
        .hready       (hready),
        .dsel         (dsel),
        .dec_err_cnt  (dec_err_cnt)
    );

    ahb_si_resp_mux #(
        .CHANNEL_NUM (3),
        .DATA_W      (32),
        .ERR_CNT_W   (2)
    ) dut2 (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .sel          (sel),
        .htrans       (htrans),
        .hrdata_in    (hrdata_in),
        .hresp_in     (hresp_in),
        .hreadyout_in (hreadyout_in),
        .hrdata       (hrdata2),
        .hresp        (hresp2),
        .hready       (hready2),
        .dsel         (dsel2),
        .dec_err_cnt  (dec_err_cnt2)
    );

    localparam logic [1:0] TrIdle   = 2'd0;
    localparam logic [1:0] TrNonseq = 2'd2;
    localparam logic [1:0] TrSeq    = 2'd3;
    localparam logic [31:0] D0 = 32'hCAFE_0000;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;
    localparam logic [31:0] D2 = 32'h2222_2222;

    typedef struct {
        logic        hready;
        logic        hresp;
        logic [31:0] hrdata;
        logic [2:0]  dsel;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   stim_done = 0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Compare both instances against one expected record; the 2-bit
    // counter must clamp at 3 where the 8-bit one keeps counting.
    task automatic chk_all(input exp_t e);
        logic [7:0] sat;
        sat = (e.cnt > 8'd3) ? 8'd3 : e.cnt;
        chk("hready",      32'(hready),       32'(e.hready));
        chk("hresp",       32'(hresp),        32'(e.hresp));
        chk("hrdata",      hrdata,            e.hrdata);
        chk("dsel",        32'(dsel),         32'(e.dsel));
        chk("dec_err_cnt", 32'(dec_err_cnt),  32'(e.cnt));
        chk("hready2",     32'(hready2),      32'(e.hready));
        chk("dec_err_cnt2", 32'(dec_err_cnt2), 32'(sat));
    endtask

    // One bus cycle: drive this cycle's address phase and slave responses,
    // and queue the expected outputs for this cycle's data phase.
    task automatic cyc(input logic [2:0] s, input logic [1:0] tr, input logic [2:0] hro,
                       input logic e_rdy, input logic e_resp, input logic [31:0] e_data,
                       input logic [2:0] e_dsel, input logic [7:0] e_cnt);
        exp_t e;
        @(posedge HCLK);
        #1;
        sel          = s;
        htrans       = tr;
        hreadyout_in = hro;
        e.hready = e_rdy;
        e.hresp  = e_resp;
        e.hrdata = e_data;
        e.dsel   = e_dsel;
        e.cnt    = e_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: checks the DUT mid-cycle whenever a response is expected.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_all(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        HRESETn      = 1'b0;
        sel          = 3'b000;
        htrans       = TrIdle;
        hresp_in     = 3'b000;
        hreadyout_in = 3'b111;
        hrdata_in[0] = D0;
        hrdata_in[1] = D1;
        hrdata_in[2] = D2;
        #12;
        // Outputs while held in reset.
        e.hready = 1'b1; e.hresp = 1'b0; e.hrdata = '0; e.dsel = '0; e.cnt = '0;
        chk_all(e);
        #11;
        HRESETn = 1'b1;

        //  sel     htrans    hro     rdy resp data dsel    cnt
        cyc(3'b000, TrIdle,   3'b111, 1, 0, '0, 3'b000, 8'd0);  // reset state
        cyc(3'b010, TrNonseq, 3'b111, 1, 0, '0, 3'b000, 8'd0);  // addr slave1
        cyc(3'b100, TrIdle,   3'b101, 0, 0, D1, 3'b010, 8'd0);  // wait 1, sel change ignored
        cyc(3'b100, TrIdle,   3'b101, 0, 0, D1, 3'b010, 8'd0);  // wait 2
        cyc(3'b000, TrIdle,   3'b111, 1, 0, D1, 3'b010, 8'd0);  // slave1 data
        cyc(3'b000, TrNonseq, 3'b111, 1, 0, '0, 3'b000, 8'd0);  // unmapped NONSEQ
        cyc(3'b000, TrIdle,   3'b111, 0, 1, '0, 3'b000, 8'd1);  // ERR1
        cyc(3'b000, TrIdle,   3'b111, 1, 1, '0, 3'b000, 8'd1);  // ERR2
        cyc(3'b101, TrNonseq, 3'b111, 1, 0, '0, 3'b000, 8'd1);  // multi-hot #1
        cyc(3'b101, TrNonseq, 3'b111, 0, 1, '0, 3'b000, 8'd2);  // ERR1 (addr held)
        cyc(3'b101, TrNonseq, 3'b111, 1, 1, '0, 3'b000, 8'd2);  // ERR2, multi-hot #2
        cyc(3'b001, TrNonseq, 3'b111, 0, 1, '0, 3'b000, 8'd3);  // ERR1 direct from ERR2
        cyc(3'b001, TrNonseq, 3'b111, 1, 1, '0, 3'b000, 8'd3);  // ERR2, slave0 captured
        cyc(3'b000, TrIdle,   3'b111, 1, 0, D0, 3'b001, 8'd3);  // slave0, no bubble
        cyc(3'b000, TrIdle,   3'b111, 1, 0, '0, 3'b000, 8'd3);  // IDLE unmapped: OKAY
        cyc(3'b000, TrIdle,   3'b111, 1, 0, '0, 3'b000, 8'd3);
        cyc(3'b110, TrSeq,    3'b111, 1, 0, '0, 3'b000, 8'd3);  // multi-hot SEQ
        cyc(3'b110, TrSeq,    3'b111, 0, 1, '0, 3'b000, 8'd4);  // ERR1
        cyc(3'b000, TrIdle,   3'b111, 1, 1, '0, 3'b000, 8'd4);  // ERR2
        cyc(3'b000, TrIdle,   3'b111, 1, 0, '0, 3'b000, 8'd4);
        cyc(3'b000, TrNonseq, 3'b111, 1, 0, '0, 3'b000, 8'd4);  // fifth error
        cyc(3'b000, TrIdle,   3'b111, 0, 1, '0, 3'b000, 8'd5);  // ERR1

        // Assert reset mid-ERR1, away from any clock edge.
        @(negedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        e.hready = 1'b1; e.hresp = 1'b0; e.hrdata = '0; e.dsel = '0; e.cnt = '0;
        chk_all(e);
        #4;
        HRESETn = 1'b1;
        cyc(3'b000, TrIdle,   3'b111, 1, 0, '0, 3'b000, 8'd0);  // still clean after release

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge HCLK);
        @(posedge HCLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
